// File: rtl/seg7_pkg.sv
// Shared segment patterns, anode positions and BCD decode for the display driver.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [1:0] AN_S_BOT = 2'd0;
    localparam logic [1:0] AN_S_TOP = 2'd1;
    localparam logic [1:0] AN_M_BOT = 2'd2;
    localparam logic [1:0] AN_M_TOP = 2'd3;

    // Non-BCD codes show a dash so a corrupted counter is visible rather than silent.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit digit to active-low {g..a} segment pattern.
// Zero latency; no flow control.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = bcd_to_seg(digit);

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode scan driver with blanking gap, frame-atomic shadow and adjust blink.
// Outputs registered (1-cycle latency from counter state); free-running, no backpressure.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 16,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       adj,
    input  logic       sel,
    input  logic [3:0] minutes_top_digit,
    input  logic [3:0] minutes_bot_digit,
    input  logic [3:0] seconds_top_digit,
    input  logic [3:0] seconds_bot_digit,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int RC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RC_W-1:0] RC_LAST  = RC_W'(REFRESH_DIV - 1);
    localparam logic [RC_W-1:0] RC_BLANK = RC_W'(BLANK_CYC);
    localparam logic [BC_W-1:0] BC_LAST  = BC_W'(BLINK_DIV - 1);

    logic [RC_W-1:0]  rc;
    logic [1:0]       slot;
    logic [BC_W-1:0]  bc;
    logic             blink_off;
    logic [3:0][3:0]  shadow;
    logic             slot_end;
    logic             frame_end;

    assign slot_end  = (rc == RC_LAST);
    assign frame_end = slot_end && (slot == AN_M_TOP);

    always_ff @(posedge clk) begin
        if (rst) begin
            rc   <= '0;
            slot <= '0;
        end else if (slot_end) begin
            rc   <= '0;
            slot <= slot + 2'd1;
        end else begin
            rc   <= rc + RC_W'(1);
        end
    end

    // Shadow is indexed by slot number so the mux below is a plain select.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
        end else if (frame_end) begin
            shadow[AN_S_BOT] <= seconds_bot_digit;
            shadow[AN_S_TOP] <= seconds_top_digit;
            shadow[AN_M_BOT] <= minutes_bot_digit;
            shadow[AN_M_TOP] <= minutes_top_digit;
        end
    end

    // Holding the blink phase at zero outside adjust makes every entry start visible.
    always_ff @(posedge clk) begin
        if (rst || !adj) begin
            bc        <= '0;
            blink_off <= 1'b0;
        end else if (bc == BC_LAST) begin
            bc        <= '0;
            blink_off <= ~blink_off;
        end else begin
            bc        <= bc + BC_W'(1);
        end
    end

    logic [3:0] cur_digit;
    logic [6:0] cur_seg;
    logic       slot_blanked;
    logic       anode_on;
    logic [3:0] an_nxt;
    logic [6:0] seg_nxt;
    logic       dp_nxt;

    assign cur_digit = shadow[slot];

    seg7_decode u_decode (
        .digit (cur_digit),
        .seg   (cur_seg)
    );

    assign slot_blanked = adj && blink_off && (sel ? !slot[1] : slot[1]);
    assign anode_on     = (rc >= RC_BLANK) && !slot_blanked;

    always_comb begin
        an_nxt  = 4'hF;
        seg_nxt = SEG_BLANK;
        dp_nxt  = 1'b1;
        if (anode_on) begin
            an_nxt[slot] = 1'b0;
            seg_nxt      = cur_seg;
            dp_nxt       = (slot != AN_M_BOT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 4'hF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised/directed bench for seg7_scan_driver against a time-based reference model.
module tb_seg7_scan_driver;

    localparam int RD = 8;
    localparam int BK = 2;
    localparam int BD = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] m_top = 4'd0, m_bot = 4'd0, s_top = 4'd0, s_bot = 4'd0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    seg7_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYC(BK), .BLINK_DIV(BD)) dut (
        .clk               (clk),
        .rst               (rst),
        .adj               (adj),
        .sel               (sel),
        .minutes_top_digit (m_top),
        .minutes_bot_digit (m_bot),
        .seconds_top_digit (s_top),
        .seconds_bot_digit (s_bot),
        .seg               (seg),
        .dp                (dp),
        .an                (an)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: cycles since reset, cycles adj has been held, displayed digits by position.
    int         t = 0;
    int         a = 0;
    logic [3:0] shd [4];
    logic [6:0] segtab [16];

    task automatic step();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        int         pos;
        bit         blanked;
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        if (!rst) begin
            pos     = (t / RD) % 4;
            blanked = adj && (((a / BD) % 2) == 1) && (sel ? (pos < 2) : (pos >= 2));
            if ((t % RD) >= BK && !blanked) begin
                e_an[pos] = 1'b0;
                e_seg     = segtab[shd[pos]];
                e_dp      = (pos == 2) ? 1'b0 : 1'b1;
            end
        end
        @(posedge clk);
        if (rst) begin
            t = 0;
            a = 0;
            for (int i = 0; i < 4; i++) shd[i] = 4'd0;
        end else begin
            if ((t % (4 * RD)) == 4 * RD - 1) begin
                shd[0] = s_bot;
                shd[1] = s_top;
                shd[2] = m_bot;
                shd[3] = m_top;
            end
            t++;
            a = adj ? a + 1 : 0;
        end
        #1;
        n_assert++;
        assert (an === e_an) else begin
            n_fail++;
            $error("FAIL an t=%0d got %b expected %b", t, an, e_an);
        end
        n_assert++;
        assert (seg === e_seg) else begin
            n_fail++;
            $error("FAIL seg t=%0d got %h expected %h", t, seg, e_seg);
        end
        n_assert++;
        assert (dp === e_dp) else begin
            n_fail++;
            $error("FAIL dp t=%0d got %b expected %b", t, dp, e_dp);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        segtab[0] = 7'h40; segtab[1] = 7'h79; segtab[2] = 7'h24; segtab[3] = 7'h30;
        segtab[4] = 7'h19; segtab[5] = 7'h12; segtab[6] = 7'h02; segtab[7] = 7'h78;
        segtab[8] = 7'h00; segtab[9] = 7'h10;
        for (int i = 10; i < 16; i++) segtab[i] = 7'h3F;
        for (int i = 0; i < 4; i++) shd[i] = 4'd0;

        // Reset, then 1,2,3,4 from minutes_top down to seconds_bot.
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        m_top = 4'd1; m_bot = 4'd2; s_top = 4'd3; s_bot = 4'd4;
        run(4 * RD * 3);

        // Mid-frame change of seconds_bot must wait for the next capture.
        run(4 * RD + 9);
        s_bot = 4'd5;
        run(4 * RD * 3);

        // Non-BCD digit shows a dash.
        s_top = 4'hC;
        run(4 * RD * 2);

        // Seconds pair blinks.
        adj = 1'b1; sel = 1'b1;
        run(5 * BD);

        // Minutes pair blinks; then drop adj while blanked.
        sel = 1'b0;
        run(3 * BD);
        for (int i = 0; i < 4 * BD && ((a / BD) % 2) != 1; i++) step();
        n_assert++;
        assert (((a / BD) % 2) == 1) else begin
            n_fail++;
            $error("FAIL blank_phase_wait got %0d expected 1", (a / BD) % 2);
        end
        adj = 1'b0;
        run(2);
        adj = 1'b1;
        run(3 * BD);

        // Random digits and mode toggling.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                m_top = 4'($urandom_range(0, 15));
                m_bot = 4'($urandom_range(0, 15));
                s_top = 4'($urandom_range(0, 15));
                s_bot = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 79) == 0) adj = ~adj;
            if ($urandom_range(0, 59) == 0) sel = ~sel;
            step();
        end

        // One-cycle reset mid-slot while adjusting.
        adj = 1'b1; sel = 1'b1;
        run(BD + 3);
        for (int i = 0; i < RD && (t % RD) != 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(4 * RD * 2 + 3 * BD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for the stopwatch's 4-digit common-anode seven-segment display. Consumes the four BCD digits from the stopwatch counter, together with its adjust/select mode inputs, and scans one digit per refresh slot with an inter-digit blanking gap. In adjust mode it blinks the selected digit pair. It uses a single clock domain with internal clock enables and no derived clocks.

## Interface
- `REFRESH_DIV`, default 100000: clk cycles per digit slot (1 ms at 100 MHz); must be ≥ `BLANK_CYC`+2.
- `BLANK_CYC`, default 16: cycles at the start of each slot with all anodes off (anti-ghosting).
- `BLINK_DIV`, default 25000000: clk cycles per blink half-period.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `adj`  in  1  adjust mode; enables blinking.
- `sel`  in  1  in adjust mode: 1 = seconds pair blinks, 0 = minutes pair blinks.
- `minutes_top_digit`, `minutes_bot_digit`, `seconds_top_digit`, `seconds_bot_digit`  in  4 each  BCD digits.
- `seg`  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal point, active-low.
- `an`  out  4  anodes, active-low; an[0]=seconds_bot, an[1]=seconds_top, an[2]=minutes_bot, an[3]=minutes_top.

## Operation
- Refresh counter `rc` counts 0..REFRESH_DIV-1 and wraps. Slot counter `slot` (2 bits) increments when `rc`==REFRESH_DIV-1, wrapping 3→0.
- Shadow register: all four digits are captured together when `rc`==REFRESH_DIV-1 and `slot`==3. A frame therefore never mixes old and new values.
- Digit decode (active-low, hex of seg): 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10. Values 10–15 display a dash (3F).
- `dp` is lit (0) only while an[2] is active, forming the mm.ss separator. Otherwise it is 1.
- Blink counter `bc` counts 0..BLINK_DIV-1 and toggles `blink_off` on wrap.
  - While `adj`=0, `bc` and `blink_off` are held at 0, so entering adjust mode always starts with a visible half-period.
- Blanking: when `adj`=1 and `blink_off`=1, slots of the selected pair drive `an` bit = 1 and `seg`=7F. The pair is slots 0–1 when `sel`=1 and slots 2–3 when `sel`=0. Unselected slots display normally.
- `sel` changes take effect on the next slot output update. `blink_off` is not reset by a `sel` change.
- Anode for the current slot is active only when `rc` ≥ BLANK_CYC. At most one `an` bit is 0 at any time.

## Timing
- Reset values: `an`=1111, `seg`=7F, `dp`=1, `rc`=0, `slot`=0, `bc`=0, `blink_off`=0, shadow digits=0.
- Reset mid-scan takes effect on the next edge. The first anode, an[0], goes low BLANK_CYC+1 cycles after `rst` deasserts.
- All outputs are registered, so `an`/`seg`/`dp` reflect the (`slot`, `rc`, `blink_off`) state of the previous cycle (1-cycle latency).
- Input-to-display latency: a digit change is visible in the frame after the next shadow capture, at most 2×4×REFRESH_DIV+1 cycles.
- Frame period is 4×REFRESH_DIV cycles. Blink full period is 2×BLINK_DIV cycles.
- If `adj` falls while `blink_off`=1, the display is restored on the next output update (1 cycle).

## Structure
- Package `seg7_pkg` holds the segment-pattern constants (digits 0–9, DASH=7'h3F, BLANK=7'h7F), the anode-index constants, and the `bcd_to_seg` decode function.
- One sub-module, `seg7_decode`, is the combinational 4-bit to 7-segment decoder. It is instantiated once on the muxed shadow digit.
- Top level contains the refresh/slot counters, blink counter, shadow register, output mux and output registers.

## Test plan
Bench parameters: REFRESH_DIV=8, BLANK_CYC=2, BLINK_DIV=32.
- Reset, then digits 1,2,3,4 (m_top..s_bot). Expect: no anode low for cycles 1–2 after reset. From the first capture on, each slot gives an[k] low for 6 cycles, with seconds_bot=4 → seg 19 on an[0] and minutes_top=1 → seg 79 on an[3].
- Change seconds_bot 4→5 mid-frame. Expect: the current frame still shows 19 on an[0]; the frame after the slot-3 capture shows 12. No frame is mixed.
- seconds_top=4'hC. Expect: an[1] shows 3F (dash). `dp`=0 only while an[2]=0.
- adj=1, sel=1. Expect: slots 0–1 visible for the first 32 cycles, then `an`[1:0] stay 1 and seg=7F for 32 cycles, alternating. Slots 2–3 are unaffected.
- adj=1, sel=0. Expect: the minutes pair blinks instead. Dropping adj while blanked restores display 1 cycle later, and `bc` returns to 0.
- Assert rst mid-slot for 1 cycle with adj=1. Expect: `an`=1111 and seg=7F next cycle, shadow=0, and blink restarting from the visible phase.
